// File: rtl/quesadilla_decode.sv
// MIPS front end: PC, instruction ROM, IF/ID register, decode with register file,
// and the ID/EX register. The PC advances sequentially, with no redirect or write-back.
module quesadilla_decode #(
    parameter int IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] dbg_pc,
    output logic [31:0] dbg_instr,
    output logic [31:0] dbg_ex_a,
    output logic [31:0] dbg_ex_b,
    output logic [31:0] dbg_ex_imm,
    output logic [4:0]  dbg_ex_wreg,
    output logic [8:0]  dbg_ex_ctrl
);
    localparam int IDX_W = $clog2(IMEM_WORDS);

    // {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[1:0]}
    localparam logic [8:0] CTRL_RTYPE = 9'h106;
    localparam logic [8:0] CTRL_ADDI  = 9'h108;
    localparam logic [8:0] CTRL_LW    = 9'h1C8;
    localparam logic [8:0] CTRL_SW    = 9'h028;
    localparam logic [8:0] CTRL_BEQ   = 9'h011;
    localparam logic [8:0] CTRL_NONE  = 9'h000;

    function automatic logic [31:0] rom_word(input logic [IDX_W-1:0] idx);
        logic [31:0] w;
        case (int'(idx))
            0:       w = 32'h0022_1820;
            1:       w = 32'h2024_0005;
            2:       w = 32'h8C45_0008;
            3:       w = 32'hAC65_000C;
            4:       w = 32'h1022_0003;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic [8:0] ctrl_decode(input logic [31:0] ins);
        logic [8:0] c;
        if (ins == 32'h0) begin
            c = CTRL_NONE;
        end else begin
            case (ins[31:26])
                6'h00:   c = CTRL_RTYPE;
                6'h08:   c = CTRL_ADDI;
                6'h23:   c = CTRL_LW;
                6'h2B:   c = CTRL_SW;
                6'h04:   c = CTRL_BEQ;
                default: c = CTRL_NONE;
            endcase
        end
        return c;
    endfunction

    function automatic logic signed [31:0] sign_extend16(input logic signed [15:0] v);
        return 32'(v);
    endfunction

    // ---- IF stage -> IF/ID register ----
    logic [31:0]      pc_p0;
    logic [31:0]      instr_p1;
    logic [IDX_W-1:0] rom_idx;

    assign rom_idx = pc_p0[IDX_W+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p0    <= 32'h0;
            instr_p1 <= 32'h0;
        end else begin
            pc_p0    <= pc_p0 + 32'd4;
            instr_p1 <= rom_word(rom_idx);
        end
    end

    // ---- ID stage (combinational on instr_p1) ----
    logic [4:0]         rs_p1;
    logic [4:0]         rt_p1;
    logic [4:0]         rd_p1;
    logic signed [31:0] imm_p1;
    logic [8:0]         ctrl_p1;
    logic [31:0]        a_p1;
    logic [31:0]        b_p1;
    logic [4:0]         wreg_p1;

    logic [31:0] regs [32];
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // No write-back path yet: the write port is present but held idle.
    assign rf_we    = 1'b0;
    assign rf_waddr = 5'd0;
    assign rf_wdata = 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'(i);
            end
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    assign rs_p1   = instr_p1[25:21];
    assign rt_p1   = instr_p1[20:16];
    assign rd_p1   = instr_p1[15:11];
    assign imm_p1  = sign_extend16(instr_p1[15:0]);
    assign ctrl_p1 = ctrl_decode(instr_p1);
    assign a_p1    = (rs_p1 == 5'd0) ? 32'h0 : regs[rs_p1];
    assign b_p1    = (rt_p1 == 5'd0) ? 32'h0 : regs[rt_p1];
    assign wreg_p1 = ctrl_p1[2] ? rd_p1 : rt_p1;

    // ---- ID/EX register ----
    logic [31:0] a_p2;
    logic [31:0] b_p2;
    logic [31:0] imm_p2;
    logic [4:0]  wreg_p2;
    logic [8:0]  ctrl_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_p2    <= 32'h0;
            b_p2    <= 32'h0;
            imm_p2  <= 32'h0;
            wreg_p2 <= 5'd0;
            ctrl_p2 <= CTRL_NONE;
        end else begin
            a_p2    <= a_p1;
            b_p2    <= b_p1;
            imm_p2  <= imm_p1;
            wreg_p2 <= wreg_p1;
            ctrl_p2 <= ctrl_p1;
        end
    end

    assign dbg_pc      = pc_p0;
    assign dbg_instr   = instr_p1;
    assign dbg_ex_a    = a_p2;
    assign dbg_ex_b    = b_p2;
    assign dbg_ex_imm  = imm_p2;
    assign dbg_ex_wreg = wreg_p2;
    assign dbg_ex_ctrl = ctrl_p2;

endmodule

// File: tb/tb_quesadilla_decode.sv
// Directed bench for quesadilla_decode: reset, fetch/decode of the ROM program,
// NOP region, ROM wrap and asynchronous mid-run reset.
module tb_quesadilla_decode;
    logic        clk;
    logic        rst;
    logic [31:0] dbg_pc;
    logic [31:0] dbg_instr;
    logic [31:0] dbg_ex_a;
    logic [31:0] dbg_ex_b;
    logic [31:0] dbg_ex_imm;
    logic [4:0]  dbg_ex_wreg;
    logic [8:0]  dbg_ex_ctrl;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_pc;

    quesadilla_decode #(.IMEM_WORDS(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .dbg_pc      (dbg_pc),
        .dbg_instr   (dbg_instr),
        .dbg_ex_a    (dbg_ex_a),
        .dbg_ex_b    (dbg_ex_b),
        .dbg_ex_imm  (dbg_ex_imm),
        .dbg_ex_wreg (dbg_ex_wreg),
        .dbg_ex_ctrl (dbg_ex_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #15;
        checks += 7;
        if (dbg_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", dbg_pc, 32'h0); end
        if (dbg_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=%h", dbg_instr, 32'h0); end
        if (dbg_ex_a !== 32'h0) begin errors++; $display("FAIL reset_a got=%h exp=0", dbg_ex_a); end
        if (dbg_ex_b !== 32'h0) begin errors++; $display("FAIL reset_b got=%h exp=0", dbg_ex_b); end
        if (dbg_ex_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got=%h exp=0", dbg_ex_imm); end
        if (dbg_ex_wreg !== 5'd0) begin errors++; $display("FAIL reset_wreg got=%0d exp=0", dbg_ex_wreg); end
        if (dbg_ex_ctrl !== 9'h000) begin errors++; $display("FAIL reset_ctrl got=%h exp=000", dbg_ex_ctrl); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        step();
        checks += 3;
        if (dbg_pc !== 32'd4) begin errors++; $display("FAIL fetch_pc got=%h exp=%h", dbg_pc, 32'd4); end
        if (dbg_instr !== 32'h0022_1820) begin errors++; $display("FAIL fetch_instr got=%h exp=%h", dbg_instr, 32'h0022_1820); end
        if (dbg_ex_ctrl !== 9'h000) begin errors++; $display("FAIL fetch_ctrl got=%h exp=000", dbg_ex_ctrl); end
    endtask

    task automatic test_add();
        step();
        checks += 7;
        if (dbg_ex_a !== 32'd1) begin errors++; $display("FAIL add_a got=%h exp=1", dbg_ex_a); end
        if (dbg_ex_b !== 32'd2) begin errors++; $display("FAIL add_b got=%h exp=2", dbg_ex_b); end
        if (dbg_ex_wreg !== 5'd3) begin errors++; $display("FAIL add_wreg got=%0d exp=3", dbg_ex_wreg); end
        if (dbg_ex_imm !== 32'h0000_1820) begin errors++; $display("FAIL add_imm got=%h exp=00001820", dbg_ex_imm); end
        if (dbg_ex_ctrl !== 9'h106) begin errors++; $display("FAIL add_ctrl got=%h exp=106", dbg_ex_ctrl); end
        if (dbg_pc !== 32'd8) begin errors++; $display("FAIL add_pc got=%h exp=8", dbg_pc); end
        if (dbg_instr !== 32'h2024_0005) begin errors++; $display("FAIL add_instr got=%h exp=20240005", dbg_instr); end
    endtask

    task automatic test_itype();
        // addi, lw, sw, beq as they reach ID/EX; instr column is the word then in IF/ID.
        logic [8:0]  t_ctrl  [4] = '{9'h108, 9'h1C8, 9'h028, 9'h011};
        logic [31:0] t_a     [4] = '{32'd1, 32'd2, 32'd3, 32'd1};
        logic [31:0] t_b     [4] = '{32'd4, 32'd5, 32'd5, 32'd2};
        logic [31:0] t_imm   [4] = '{32'd5, 32'd8, 32'd12, 32'd3};
        logic [4:0]  t_wreg  [4] = '{5'd4, 5'd5, 5'd5, 5'd2};
        logic [31:0] t_pc    [4] = '{32'd12, 32'd16, 32'd20, 32'd24};
        logic [31:0] t_instr [4] = '{32'h8C45_0008, 32'hAC65_000C, 32'h1022_0003, 32'h0};
        for (int i = 0; i < 4; i++) begin
            step();
            checks += 7;
            if (dbg_ex_ctrl !== t_ctrl[i]) begin errors++; $display("FAIL itype%0d_ctrl got=%h exp=%h", i, dbg_ex_ctrl, t_ctrl[i]); end
            if (dbg_ex_a !== t_a[i]) begin errors++; $display("FAIL itype%0d_a got=%h exp=%h", i, dbg_ex_a, t_a[i]); end
            if (dbg_ex_b !== t_b[i]) begin errors++; $display("FAIL itype%0d_b got=%h exp=%h", i, dbg_ex_b, t_b[i]); end
            if (dbg_ex_imm !== t_imm[i]) begin errors++; $display("FAIL itype%0d_imm got=%h exp=%h", i, dbg_ex_imm, t_imm[i]); end
            if (dbg_ex_wreg !== t_wreg[i]) begin errors++; $display("FAIL itype%0d_wreg got=%0d exp=%0d", i, dbg_ex_wreg, t_wreg[i]); end
            if (dbg_pc !== t_pc[i]) begin errors++; $display("FAIL itype%0d_pc got=%h exp=%h", i, dbg_pc, t_pc[i]); end
            if (dbg_instr !== t_instr[i]) begin errors++; $display("FAIL itype%0d_instr got=%h exp=%h", i, dbg_instr, t_instr[i]); end
        end
    endtask

    task automatic test_nop_and_wrap();
        exp_pc = 32'd24;
        // Steps up to pc=0x100: IF/ID and ID/EX both hold NOPs.
        for (int i = 0; i < 58; i++) begin
            step();
            exp_pc = exp_pc + 32'd4;
            checks += 6;
            if (dbg_pc !== exp_pc) begin errors++; $display("FAIL nop_pc got=%h exp=%h", dbg_pc, exp_pc); end
            if (dbg_instr !== 32'h0) begin errors++; $display("FAIL nop_instr pc=%h got=%h exp=0", dbg_pc, dbg_instr); end
            if (dbg_ex_ctrl !== 9'h000) begin errors++; $display("FAIL nop_ctrl pc=%h got=%h exp=000", dbg_pc, dbg_ex_ctrl); end
            if (dbg_ex_a !== 32'h0) begin errors++; $display("FAIL nop_a pc=%h got=%h exp=0", dbg_pc, dbg_ex_a); end
            if (dbg_ex_imm !== 32'h0) begin errors++; $display("FAIL nop_imm pc=%h got=%h exp=0", dbg_pc, dbg_ex_imm); end
            if (dbg_ex_wreg !== 5'd0) begin errors++; $display("FAIL nop_wreg pc=%h got=%0d exp=0", dbg_pc, dbg_ex_wreg); end
        end
        step();
        checks += 2;
        if (dbg_pc !== 32'h104) begin errors++; $display("FAIL wrap_pc got=%h exp=00000104", dbg_pc); end
        if (dbg_instr !== 32'h0022_1820) begin errors++; $display("FAIL wrap_instr got=%h exp=00221820", dbg_instr); end
        step();
        checks += 3;
        if (dbg_ex_ctrl !== 9'h106) begin errors++; $display("FAIL wrap_ctrl got=%h exp=106", dbg_ex_ctrl); end
        if (dbg_ex_wreg !== 5'd3) begin errors++; $display("FAIL wrap_wreg got=%0d exp=3", dbg_ex_wreg); end
        if (dbg_instr !== 32'h2024_0005) begin errors++; $display("FAIL wrap_instr2 got=%h exp=20240005", dbg_instr); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        step();
        checks += 2;
        if (dbg_pc !== 32'h0C) begin errors++; $display("FAIL pre_rst_pc got=%h exp=0000000c", dbg_pc); end
        if (dbg_ex_ctrl !== 9'h108) begin errors++; $display("FAIL pre_rst_ctrl got=%h exp=108", dbg_ex_ctrl); end
        #2;
        rst = 1'b1;
        #1;
        checks += 7;
        if (dbg_pc !== 32'h0) begin errors++; $display("FAIL async_pc got=%h exp=0", dbg_pc); end
        if (dbg_instr !== 32'h0) begin errors++; $display("FAIL async_instr got=%h exp=0", dbg_instr); end
        if (dbg_ex_a !== 32'h0) begin errors++; $display("FAIL async_a got=%h exp=0", dbg_ex_a); end
        if (dbg_ex_b !== 32'h0) begin errors++; $display("FAIL async_b got=%h exp=0", dbg_ex_b); end
        if (dbg_ex_imm !== 32'h0) begin errors++; $display("FAIL async_imm got=%h exp=0", dbg_ex_imm); end
        if (dbg_ex_wreg !== 5'd0) begin errors++; $display("FAIL async_wreg got=%0d exp=0", dbg_ex_wreg); end
        if (dbg_ex_ctrl !== 9'h000) begin errors++; $display("FAIL async_ctrl got=%h exp=000", dbg_ex_ctrl); end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks += 2;
        if (dbg_pc !== 32'd4) begin errors++; $display("FAIL restart_pc got=%h exp=4", dbg_pc); end
        if (dbg_instr !== 32'h0022_1820) begin errors++; $display("FAIL restart_instr got=%h exp=00221820", dbg_instr); end
        step();
        checks += 3;
        if (dbg_ex_ctrl !== 9'h106) begin errors++; $display("FAIL restart_ctrl got=%h exp=106", dbg_ex_ctrl); end
        if (dbg_ex_a !== 32'd1) begin errors++; $display("FAIL restart_a got=%h exp=1", dbg_ex_a); end
        if (dbg_ex_b !== 32'd2) begin errors++; $display("FAIL restart_b got=%h exp=2", dbg_ex_b); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_first_fetch();
        test_add();
        test_itype();
        test_nop_and_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quesadilla_decode.md
Name: quesadilla_decode

Overview:
- Self-contained front end of the 5-stage MIPS pipeline: IF stage, IF/ID register, ID stage and ID/EX register.
- Contains the PC, an internal 64-word instruction ROM, a 32x32 register file and the main control decoder.
- Top-level interface is clock and reset only; debug outputs expose pipeline state for checking.
- No write-back, hazard or branch-redirect logic: the PC always advances sequentially.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words; index = pc[7:2], wraps modulo depth.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- dbg_pc  out  32  current PC.
- dbg_instr  out  32  IF/ID instruction register.
- dbg_ex_a  out  32  ID/EX rs read data.
- dbg_ex_b  out  32  ID/EX rt read data.
- dbg_ex_imm  out  32  ID/EX sign-extended imm[15:0].
- dbg_ex_wreg  out  5  ID/EX destination register.
- dbg_ex_ctrl  out  9  ID/EX control word {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[1:0]}.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - While rst=1: pc=0, IF/ID instr=0 (NOP), all ID/EX fields=0, regfile reg[i]=i for i=0..31.
- IF stage, each rising edge with rst=0:
  - pc <= pc+4, wrapping at 32 bits.
  - IF/ID instr <= ROM[pc[7:2]].
- ROM contents:
  - Fixed at elaboration.
  - Word0 = 0x00221820 (add $3,$1,$2).
  - Word1 = 0x20240005 (addi $4,$1,5).
  - Word2 = 0x8C450008 (lw $5,8($2)).
  - Word3 = 0xAC65000C (sw $5,12($3)).
  - Word4 = 0x10220003 (beq $1,$2,3).
  - All other words = 0 (NOP).
- ID stage, combinational on the IF/ID instr:
  - Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
  - Register file reads rs and rt asynchronously; reg0 always reads 0.
  - Register-file write port exists but is tied inactive (we=0); contents stay at reset values.
  - imm is sign-extended to 32 bits.
  - wreg = rd when reg_dst=1, else rt.
- Control decode (ctrl as a 9-bit hex value):
  - R-type (opcode 0x00, instr != 0): 0x106.
  - addi (0x08): 0x108.
  - lw (0x23): 0x1C8.
  - sw (0x2B): 0x028.
  - beq (0x04): 0x011.
  - instr == 0 or any other opcode: 0x000.
- ID/EX register, each rising edge with rst=0: captures a, b, imm, wreg and ctrl from the current decode.
- Latency:
  - The instruction at ROM word k appears on dbg_instr 1 edge after the PC presents address 4k.
  - Its decoded fields appear on the dbg_ex_* outputs 1 edge later (2 edges after fetch).
- Branch handling: beq is decoded only; no PC redirect and no flush.
- Reset mid-operation: all state returns to reset values immediately (asynchronously); fetch restarts at word0 on the first edge after release.
- Sequential behaviour after the program:
  - Execution runs past word4 into NOPs, with ctrl=0 and all ID/EX fields 0.
  - At pc=0x100 the ROM index wraps and the program replays.

Test Plan:
- Reset: hold rst=1 for 15 ns (10 ns clock period) -> dbg_pc=0, dbg_instr=0, dbg_ex_ctrl=0x000, all dbg_ex_* = 0.
- First fetch: first edge after release -> dbg_pc=4, dbg_instr=0x00221820.
- add decode: second edge after release -> dbg_ex_a=1, dbg_ex_b=2, dbg_ex_wreg=3, dbg_ex_imm=0x00001820, dbg_ex_ctrl=0x106.
- I-type decodes:
  - addi: ctrl 0x108, a=1, wreg=4, imm=5.
  - lw: ctrl 0x1C8, a=2, wreg=5, imm=8.
  - sw: ctrl 0x028, a=3, b=5, imm=12.
  - beq: ctrl 0x011, a=1, b=2, imm=3; dbg_pc still increments by 4 after beq.
- NOP region: run 200 ns after release -> dbg_instr=0 and dbg_ex_ctrl=0x000 from word5 onward.
- Mid-run reset: assert rst between clock edges at pc=0x0C -> all outputs zero without waiting for a clock edge; after release the sequence restarts with dbg_instr=0x00221820.
